// File: rtl/wb_regfile_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_sink_pkg
// Brief    : Core-wide widths, exception causes and scoreboard entry type.
// Revision : 1.0 - initial release
// ============================================================================
package wb_regfile_sink_pkg;

    localparam int WBR_THR_PER_CORE = 4;
    localparam int WBR_NUM_REGS     = 32;
    localparam int WBR_DATA_W       = 32;
    localparam int WBR_ROB_ID_W     = 4;
    localparam int WBR_PC_W         = 32;
    localparam int WBR_XCPT_ADDR_W  = 32;

    typedef enum logic [2:0] {
        XCPT_NONE          = 3'd0,
        XCPT_ILLEGAL_INSTR = 3'd1,
        XCPT_IFETCH_FAULT  = 3'd2,
        XCPT_LOAD_FAULT    = 3'd3,
        XCPT_STORE_FAULT   = 3'd4,
        XCPT_SYSCALL       = 3'd5
    } xcpt_type_t;

    typedef struct packed {
        logic                    pending;
        logic [WBR_ROB_ID_W-1:0] rob_id;
    } rf_scoreboard_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_regfile_sink_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Brief    : Per-thread pending/producer-id table with flush > alloc > clear
//            priority and write-first read lookup.
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import wb_regfile_sink_pkg::*;
#(
    parameter int THR_PER_CORE = WBR_THR_PER_CORE,
    parameter int NUM_REGS     = WBR_NUM_REGS,
    localparam int THR_W       = $clog2(THR_PER_CORE),
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_alloc_valid,
    input  logic [ADDR_W-1:0]       i_alloc_dest,
    input  logic [WBR_ROB_ID_W-1:0] i_alloc_rob_id,
    input  logic [THR_W-1:0]        i_alloc_thread_id,
    // Commit already qualified: non-zero dest and thread not being flushed.
    input  logic                    i_commit_valid,
    input  logic [ADDR_W-1:0]       i_commit_dest,
    input  logic [WBR_ROB_ID_W-1:0] i_commit_rob_id,
    input  logic [THR_W-1:0]        i_commit_thread_id,
    input  logic                    i_flush_valid,
    input  logic [THR_W-1:0]        i_flush_thread_id,
    input  logic [THR_W-1:0]        i_rd_thread_id,
    input  logic [ADDR_W-1:0]       i_rd_src1_addr,
    input  logic [ADDR_W-1:0]       i_rd_src2_addr,
    output logic                    o_rd_src1_pending,
    output logic [WBR_ROB_ID_W-1:0] o_rd_src1_rob_id,
    output logic                    o_rd_src2_pending,
    output logic [WBR_ROB_ID_W-1:0] o_rd_src2_rob_id
);

    rf_scoreboard_entry_t r_sb [THR_PER_CORE][NUM_REGS];
    rf_scoreboard_entry_t w_src1;
    rf_scoreboard_entry_t w_src2;
    logic                 w_fwd1_clr;
    logic                 w_fwd2_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < THR_PER_CORE; t++) begin
                for (int d = 0; d < NUM_REGS; d++) begin
                    r_sb[t][d] <= '0;
                end
            end
        end else begin
            // Register 0 is never touched, so it stays at its reset value.
            for (int t = 0; t < THR_PER_CORE; t++) begin
                for (int d = 1; d < NUM_REGS; d++) begin
                    if (i_flush_valid && (i_flush_thread_id == THR_W'(t))) begin
                        r_sb[t][d].pending <= 1'b0;
                    end else if (i_alloc_valid && (i_alloc_thread_id == THR_W'(t)) &&
                                 (i_alloc_dest == ADDR_W'(d))) begin
                        r_sb[t][d].pending <= 1'b1;
                        r_sb[t][d].rob_id  <= i_alloc_rob_id;
                    end else if (i_commit_valid && (i_commit_thread_id == THR_W'(t)) &&
                                 (i_commit_dest == ADDR_W'(d)) && r_sb[t][d].pending &&
                                 (r_sb[t][d].rob_id == i_commit_rob_id)) begin
                        r_sb[t][d].pending <= 1'b0;
                    end
                end
            end
        end
    end

    // Same-cycle clear is forwarded; a same-cycle alloc only shows next cycle.
    always_comb begin
        w_src1     = r_sb[i_rd_thread_id][i_rd_src1_addr];
        w_src2     = r_sb[i_rd_thread_id][i_rd_src2_addr];
        w_fwd1_clr = i_commit_valid && (i_commit_thread_id == i_rd_thread_id) &&
                     (i_commit_dest == i_rd_src1_addr) && (w_src1.rob_id == i_commit_rob_id);
        w_fwd2_clr = i_commit_valid && (i_commit_thread_id == i_rd_thread_id) &&
                     (i_commit_dest == i_rd_src2_addr) && (w_src2.rob_id == i_commit_rob_id);
        o_rd_src1_pending = w_src1.pending && !w_fwd1_clr;
        o_rd_src2_pending = w_src2.pending && !w_fwd2_clr;
        o_rd_src1_rob_id  = w_src1.rob_id;
        o_rd_src2_rob_id  = w_src2.rob_id;
    end

endmodule
`default_nettype wire

// File: rtl/wb_regfile_sink.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_sink
// Brief    : Writeback commit sink: multi-thread register file, pending
//            scoreboard, per-thread exception registers and privilege bits.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile_sink
    import wb_regfile_sink_pkg::*;
#(
    parameter int THR_PER_CORE = WBR_THR_PER_CORE,
    parameter int NUM_REGS     = WBR_NUM_REGS,
    parameter int DATA_W       = WBR_DATA_W,
    parameter int ROB_ID_W     = WBR_ROB_ID_W,
    parameter int PC_W         = WBR_PC_W,
    parameter int XCPT_ADDR_W  = WBR_XCPT_ADDR_W,
    localparam int THR_W       = $clog2(THR_PER_CORE),
    localparam int ADDR_W      = $clog2(NUM_REGS),
    localparam int XTYPE_W     = $bits(xcpt_type_t)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            wb_writeEn,
    input  logic [DATA_W-1:0]               wb_data,
    input  logic [ADDR_W-1:0]               wb_dest,
    input  logic [ROB_ID_W-1:0]             wb_instr_id,
    input  logic [THR_W-1:0]                wb_thread_id,
    input  logic                            xcpt_valid,
    input  xcpt_type_t                      xcpt_type,
    input  logic [PC_W-1:0]                 xcpt_pc,
    input  logic [XCPT_ADDR_W-1:0]          xcpt_addr,
    input  logic [THR_W-1:0]                xcpt_thread_id,
    input  logic                            alloc_valid,
    input  logic [ADDR_W-1:0]               alloc_dest,
    input  logic [ROB_ID_W-1:0]             alloc_rob_id,
    input  logic [THR_W-1:0]                alloc_thread_id,
    input  logic                            iret_valid,
    input  logic [THR_W-1:0]                iret_thread_id,
    input  logic [THR_W-1:0]                rd_thread_id,
    input  logic [ADDR_W-1:0]               rd_src1_addr,
    input  logic [ADDR_W-1:0]               rd_src2_addr,
    output logic [DATA_W-1:0]               rd_src1_data,
    output logic [DATA_W-1:0]               rd_src2_data,
    output logic                            rd_src1_pending,
    output logic                            rd_src2_pending,
    output logic [ROB_ID_W-1:0]             rd_src1_rob_id,
    output logic [ROB_ID_W-1:0]             rd_src2_rob_id,
    output logic [THR_PER_CORE*PC_W-1:0]    xcpt_pc_out,
    output logic [THR_PER_CORE*XCPT_ADDR_W-1:0] xcpt_addr_out,
    output logic [THR_PER_CORE*XTYPE_W-1:0] xcpt_type_out,
    output logic [THR_PER_CORE-1:0]         priv_mode
);

    logic [DATA_W-1:0]      r_regs [THR_PER_CORE][NUM_REGS];
    logic [PC_W-1:0]        r_rm0  [THR_PER_CORE];
    logic [XCPT_ADDR_W-1:0] r_rm1  [THR_PER_CORE];
    xcpt_type_t             r_rm2  [THR_PER_CORE];
    logic [THR_PER_CORE-1:0] r_priv;
    logic                   w_wb_commit;

    // The excepting instruction's own write must not land.
    assign w_wb_commit = wb_writeEn && (wb_dest != '0) &&
                         !(xcpt_valid && (xcpt_thread_id == wb_thread_id));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < THR_PER_CORE; t++) begin
                for (int d = 0; d < NUM_REGS; d++) begin
                    r_regs[t][d] <= '0;
                end
                r_rm0[t] <= '0;
                r_rm1[t] <= '0;
                r_rm2[t] <= XCPT_NONE;
            end
            r_priv <= '1;
        end else begin
            if (w_wb_commit) begin
                r_regs[wb_thread_id][wb_dest] <= wb_data;
            end
            if (iret_valid) begin
                r_priv[iret_thread_id] <= 1'b0;
            end
            // Placed after iret so a same-thread exception overrides it.
            if (xcpt_valid) begin
                r_rm0[xcpt_thread_id]  <= xcpt_pc;
                r_rm1[xcpt_thread_id]  <= xcpt_addr;
                r_rm2[xcpt_thread_id]  <= xcpt_type;
                r_priv[xcpt_thread_id] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_src1_data = r_regs[rd_thread_id][rd_src1_addr];
        rd_src2_data = r_regs[rd_thread_id][rd_src2_addr];
        if (w_wb_commit && (wb_thread_id == rd_thread_id) && (wb_dest == rd_src1_addr)) begin
            rd_src1_data = wb_data;
        end
        if (w_wb_commit && (wb_thread_id == rd_thread_id) && (wb_dest == rd_src2_addr)) begin
            rd_src2_data = wb_data;
        end
    end

    rf_scoreboard #(
        .THR_PER_CORE (THR_PER_CORE),
        .NUM_REGS     (NUM_REGS)
    ) u_scoreboard (
        .clk                (clock),
        .rst                (reset),
        .i_alloc_valid      (alloc_valid),
        .i_alloc_dest       (alloc_dest),
        .i_alloc_rob_id     (alloc_rob_id),
        .i_alloc_thread_id  (alloc_thread_id),
        .i_commit_valid     (w_wb_commit),
        .i_commit_dest      (wb_dest),
        .i_commit_rob_id    (wb_instr_id),
        .i_commit_thread_id (wb_thread_id),
        .i_flush_valid      (xcpt_valid),
        .i_flush_thread_id  (xcpt_thread_id),
        .i_rd_thread_id     (rd_thread_id),
        .i_rd_src1_addr     (rd_src1_addr),
        .i_rd_src2_addr     (rd_src2_addr),
        .o_rd_src1_pending  (rd_src1_pending),
        .o_rd_src1_rob_id   (rd_src1_rob_id),
        .o_rd_src2_pending  (rd_src2_pending),
        .o_rd_src2_rob_id   (rd_src2_rob_id)
    );

    for (genvar t = 0; t < THR_PER_CORE; t++) begin : g_xcpt_out
        assign xcpt_pc_out[t*PC_W +: PC_W]                 = r_rm0[t];
        assign xcpt_addr_out[t*XCPT_ADDR_W +: XCPT_ADDR_W] = r_rm1[t];
        assign xcpt_type_out[t*XTYPE_W +: XTYPE_W]         = r_rm2[t];
    end

    assign priv_mode = r_priv;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile_sink
// Brief    : Directed scoreboard bench for wb_regfile_sink.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_sink;
    import wb_regfile_sink_pkg::*;

    localparam int c_thr_w  = 2;
    localparam int c_addr_w = 5;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 wb_writeEn;
    logic [31:0]          wb_data;
    logic [c_addr_w-1:0]  wb_dest;
    logic [3:0]           wb_instr_id;
    logic [c_thr_w-1:0]   wb_thread_id;
    logic                 xcpt_valid;
    xcpt_type_t           xcpt_type;
    logic [31:0]          xcpt_pc;
    logic [31:0]          xcpt_addr;
    logic [c_thr_w-1:0]   xcpt_thread_id;
    logic                 alloc_valid;
    logic [c_addr_w-1:0]  alloc_dest;
    logic [3:0]           alloc_rob_id;
    logic [c_thr_w-1:0]   alloc_thread_id;
    logic                 iret_valid;
    logic [c_thr_w-1:0]   iret_thread_id;
    logic [c_thr_w-1:0]   rd_thread_id;
    logic [c_addr_w-1:0]  rd_src1_addr;
    logic [c_addr_w-1:0]  rd_src2_addr;
    logic [31:0]          rd_src1_data;
    logic [31:0]          rd_src2_data;
    logic                 rd_src1_pending;
    logic                 rd_src2_pending;
    logic [3:0]           rd_src1_rob_id;
    logic [3:0]           rd_src2_rob_id;
    logic [127:0]         xcpt_pc_out;
    logic [127:0]         xcpt_addr_out;
    logic [11:0]          xcpt_type_out;
    logic [3:0]           priv_mode;

    wb_regfile_sink dut (
        .clock(clock), .reset(reset),
        .wb_writeEn(wb_writeEn), .wb_data(wb_data), .wb_dest(wb_dest),
        .wb_instr_id(wb_instr_id), .wb_thread_id(wb_thread_id),
        .xcpt_valid(xcpt_valid), .xcpt_type(xcpt_type), .xcpt_pc(xcpt_pc),
        .xcpt_addr(xcpt_addr), .xcpt_thread_id(xcpt_thread_id),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .alloc_rob_id(alloc_rob_id), .alloc_thread_id(alloc_thread_id),
        .iret_valid(iret_valid), .iret_thread_id(iret_thread_id),
        .rd_thread_id(rd_thread_id), .rd_src1_addr(rd_src1_addr), .rd_src2_addr(rd_src2_addr),
        .rd_src1_data(rd_src1_data), .rd_src2_data(rd_src2_data),
        .rd_src1_pending(rd_src1_pending), .rd_src2_pending(rd_src2_pending),
        .rd_src1_rob_id(rd_src1_rob_id), .rd_src2_rob_id(rd_src2_rob_id),
        .xcpt_pc_out(xcpt_pc_out), .xcpt_addr_out(xcpt_addr_out),
        .xcpt_type_out(xcpt_type_out), .priv_mode(priv_mode)
    );

    always #5 clock = ~clock;

    // Selectors for which DUT output an expectation refers to.
    localparam int S_D1 = 0, S_P1 = 1, S_ID1 = 2, S_D2 = 3, S_P2 = 4, S_ID2 = 5;
    localparam int S_PRIV = 6, S_RM0 = 7, S_RM1 = 8, S_RM2 = 9;

    typedef struct {
        string       name;
        int          sel;
        int          thr;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [63:0] actual(input int sel, input int thr);
        case (sel)
            S_D1:    return 64'(rd_src1_data);
            S_P1:    return 64'(rd_src1_pending);
            S_ID1:   return 64'(rd_src1_rob_id);
            S_D2:    return 64'(rd_src2_data);
            S_P2:    return 64'(rd_src2_pending);
            S_ID2:   return 64'(rd_src2_rob_id);
            S_PRIV:  return 64'(priv_mode);
            S_RM0:   return 64'(xcpt_pc_out[thr*32 +: 32]);
            S_RM1:   return 64'(xcpt_addr_out[thr*32 +: 32]);
            S_RM2:   return 64'(xcpt_type_out[thr*3 +: 3]);
            default: return 64'hBAD;
        endcase
    endfunction

    // Monitor: outputs are combinational, checked mid-cycle on the falling edge.
    initial begin : monitor
        exp_t        e;
        logic [63:0] a;
        forever begin
            @(negedge clock);
            while (q.size() > 0) begin
                e = q.pop_front();
                a = actual(e.sel, e.thr);
                vectors++;
                if (a !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.exp);
                end
            end
        end
    end

    task automatic push(input string n, input int sel, input int thr, input logic [63:0] v);
        q.push_back('{n, sel, thr, v});
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wb_writeEn = 0; wb_data = '0; wb_dest = '0; wb_instr_id = '0; wb_thread_id = '0;
        xcpt_valid = 0; xcpt_type = XCPT_NONE; xcpt_pc = '0; xcpt_addr = '0; xcpt_thread_id = '0;
        alloc_valid = 0; alloc_dest = '0; alloc_rob_id = '0; alloc_thread_id = '0;
        iret_valid = 0; iret_thread_id = '0;
        rd_thread_id = '0; rd_src1_addr = '0; rd_src2_addr = '0;
    endtask

    task automatic rd(input int t, input int a1, input int a2);
        rd_thread_id = c_thr_w'(t); rd_src1_addr = c_addr_w'(a1); rd_src2_addr = c_addr_w'(a2);
    endtask

    task automatic alloc(input int t, input int d, input int id);
        alloc_valid = 1; alloc_thread_id = c_thr_w'(t); alloc_dest = c_addr_w'(d); alloc_rob_id = 4'(id);
    endtask

    task automatic commit(input int t, input int d, input int id, input logic [31:0] v);
        wb_writeEn = 1; wb_thread_id = c_thr_w'(t); wb_dest = c_addr_w'(d);
        wb_instr_id = 4'(id); wb_data = v;
    endtask

    task automatic xcpt(input int t, input logic [31:0] pc, input logic [31:0] addr, input xcpt_type_t ty);
        xcpt_valid = 1; xcpt_thread_id = c_thr_w'(t); xcpt_pc = pc; xcpt_addr = addr; xcpt_type = ty;
    endtask

    task automatic iret(input int t);
        iret_valid = 1; iret_thread_id = c_thr_w'(t);
    endtask

    initial begin : stimulus
        idle(); reset = 1;
        cyc(); cyc();

        reset = 0; rd(2, 5, 0);
        push("rst_data", S_D1, 0, 0); push("rst_pend", S_P1, 0, 0);
        push("rst_priv", S_PRIV, 0, 64'hF); push("rst_rm0_t1", S_RM0, 1, 0);
        push("rst_rm2_t3", S_RM2, 3, 0);
        cyc();

        idle(); alloc(1, 3, 6); cyc();
        idle(); rd(1, 3, 0);
        push("alloc_pend", S_P1, 0, 1); push("alloc_id", S_ID1, 0, 6);
        cyc();
        idle(); commit(1, 3, 6, 32'hDEADBEEF); rd(1, 3, 0);
        push("fwd_data", S_D1, 0, 64'hDEADBEEF); push("fwd_clr", S_P1, 0, 0);
        cyc();
        idle(); rd(1, 3, 0);
        push("array_data", S_D1, 0, 64'hDEADBEEF); push("array_pend", S_P1, 0, 0);
        cyc();

        idle(); alloc(0, 7, 2); cyc();
        idle(); alloc(0, 7, 5); cyc();
        idle(); commit(0, 7, 2, 32'h11); rd(0, 7, 7);
        push("old_commit_data", S_D1, 0, 64'h11); push("old_commit_pend", S_P1, 0, 1);
        push("old_commit_id", S_ID2, 0, 5);
        cyc();
        idle(); rd(0, 7, 7);
        push("young_pend", S_P2, 0, 1); push("young_id", S_ID1, 0, 5); push("old_data", S_D2, 0, 64'h11);
        cyc();
        idle(); commit(0, 7, 5, 32'h22); rd(0, 7, 0);
        push("young_clr_fwd", S_P1, 0, 0); push("young_data_fwd", S_D1, 0, 64'h22);
        cyc();
        idle(); rd(0, 7, 0);
        push("young_clr", S_P1, 0, 0); push("young_data", S_D1, 0, 64'h22);
        cyc();

        idle(); commit(0, 0, 0, 32'hFF); alloc(0, 0, 3); rd(0, 0, 0);
        push("r0_fwd", S_D1, 0, 0);
        cyc();
        idle(); rd(0, 0, 0);
        push("r0_data", S_D1, 0, 0); push("r0_pend", S_P1, 0, 0);
        cyc();

        idle(); iret(3); cyc();
        idle(); alloc(3, 4, 1);
        push("iret_t3_priv", S_PRIV, 0, 64'h7);
        cyc();
        idle(); xcpt(3, 32'h1000, 32'h2004, XCPT_LOAD_FAULT); commit(3, 9, 3, 32'h55); alloc(3, 6, 7);
        cyc();
        idle(); rd(3, 4, 9);
        push("xcpt_flush_r4", S_P1, 0, 0); push("xcpt_drop_r9", S_D2, 0, 0);
        push("xcpt_rm0", S_RM0, 3, 64'h1000); push("xcpt_rm1", S_RM1, 3, 64'h2004);
        push("xcpt_rm2", S_RM2, 3, 64'(XCPT_LOAD_FAULT)); push("xcpt_priv", S_PRIV, 0, 64'hF);
        cyc();
        idle(); rd(3, 6, 0);
        push("xcpt_drop_alloc", S_P1, 0, 0);
        cyc();
        idle(); rd(0, 7, 0);
        push("t0_intact_data", S_D1, 0, 64'h22); push("t0_rm0", S_RM0, 0, 0);
        cyc();
        idle(); rd(1, 3, 0);
        push("t1_intact_data", S_D1, 0, 64'hDEADBEEF);
        cyc();

        idle(); iret(2); cyc();
        idle(); push("iret_t2_priv", S_PRIV, 0, 64'hB);
        iret(2); xcpt(2, 32'h3000, 32'h40, XCPT_SYSCALL);
        cyc();
        idle();
        push("iret_vs_xcpt_priv", S_PRIV, 0, 64'hF); push("t2_rm0", S_RM0, 2, 64'h3000);
        push("t2_rm2", S_RM2, 2, 64'(XCPT_SYSCALL));
        cyc();

        idle(); alloc(1, 10, 4); cyc();
        idle(); commit(1, 10, 4, 32'hA5); alloc(1, 10, 9); rd(1, 10, 0);
        push("alloc_clr_same_pend", S_P1, 0, 0); push("alloc_clr_same_data", S_D1, 0, 64'hA5);
        cyc();
        idle(); rd(1, 10, 0);
        push("alloc_wins_pend", S_P1, 0, 1); push("alloc_wins_id", S_ID1, 0, 9);
        push("alloc_wins_data", S_D1, 0, 64'hA5);
        cyc();

        idle(); reset = 1; alloc(0, 12, 3); commit(0, 12, 3, 32'h77); cyc();
        idle(); reset = 0; rd(0, 12, 7);
        push("midrst_data", S_D1, 0, 0); push("midrst_pend", S_P1, 0, 0);
        push("midrst_r7", S_D2, 0, 0); push("midrst_priv", S_PRIV, 0, 64'hF);
        cyc();

        cyc(); cyc();
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL monitor_drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
